dpram_port_arbiter: RTL and testbench

//  Shares one dual-port, 2-read/write block RAM between NREQ single-cycle requesters.
//  - Up to two requests are granted per cycle: one on RAM port A, one on port B.
//  - Selection is round-robin.
//  - Same-address conflicts that involve a write are resolved.
//  - Read data is routed back to its requester one cycle after the grant.
//  - Sits between client engines and the dual-port RAM; both RAM clocks are tied to clk.

---
 rtl/dpram_arb_pkg.sv | 52 +++++
 rtl/dpram_port_arbiter_if.sv | 33 +++
 rtl/dpram_rr_pick.sv | 26 ++
 rtl/dpram_port_arbiter.sv | 113 +++++++++++
 tb/tb_dpram_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM request arbiter.
// Index fields are sized for the largest supported requester count (16).
package dpram_arb_pkg;

  localparam int NREQ_MAX = 16;
  localparam int IDX_W    = 4;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    port_e            port;
  } tag_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of mask scanning upward from ptr, wrapping at n-1 -> 0.
  function automatic pick_t rr_first(input logic [NREQ_MAX-1:0] mask,
                                     input logic [IDX_W-1:0]    ptr,
                                     input int                  n);
    pick_t          res;
    logic [IDX_W:0] j;
    res = '0;
    for (int k = NREQ_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        j = {1'b0, ptr} + (IDX_W+1)'(k);
        if (j >= (IDX_W+1)'(n)) j = j - (IDX_W+1)'(n);
        if (mask[j[IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i,
                                                input int               n);
    logic [IDX_W:0] s;
    s = {1'b0, i} + (IDX_W+1)'(1);
    if (s >= (IDX_W+1)'(n)) s = '0;
    return s[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_if.sv
// Client-side request/grant/return bundle plus the two RAM port buses.
// Handshake: req is held until gnt is seen in the same cycle; rvalid/rdata arrive one cycle after a read grant.
interface dpram_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 6,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;

  logic               ram_ena, ram_enb;
  logic               ram_wea, ram_web;
  logic [AW-1:0]      ram_addra, ram_addrb;
  logic [DW-1:0]      ram_dia, ram_dib;
  logic [DW-1:0]      ram_doa, ram_dob;

  modport master (
    output req, req_we, req_addr, req_wdata, ram_doa, ram_dob,
    input  gnt, rvalid, rdata,
    input  ram_ena, ram_enb, ram_wea, ram_web, ram_addra, ram_addrb, ram_dia, ram_dib
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, ram_doa, ram_dob,
    output gnt, rvalid, rdata,
    output ram_ena, ram_enb, ram_wea, ram_web, ram_addra, ram_addrb, ram_dia, ram_dib
  );
endinterface

// File: rtl/dpram_rr_pick.sv
// One-hot round-robin picker: first eligible requester at or after ptr.
module dpram_rr_pick
  import dpram_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt_oh,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  logic [NREQ_MAX-1:0] elig;
  pick_t               pick;

  always_comb begin
    elig           = '0;
    elig[NREQ-1:0] = req & mask;
    pick           = rr_first(elig, ptr, NREQ);
    valid          = pick.found;
    idx            = pick.idx;
    gnt_oh         = '0;
    for (int i = 0; i < NREQ; i++) gnt_oh[i] = pick.found && (pick.idx == IDX_W'(i));
  end
endmodule

// File: rtl/dpram_port_arbiter.sv
// Grants up to two single-cycle requests per cycle onto RAM ports A/B,
// resolves write conflicts, and routes the single read return back to its requester.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 6,
  parameter int DW   = 16,
  parameter int CW   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  dpram_port_arbiter_if.slave bus,
  output logic [CW-1:0]       coll_cnt
);
  logic [NREQ-1:0]  a_oh, b_oh, mask_b;
  logic             a_vld, b_vld, a_we, b_we;
  logic [IDX_W-1:0] a_idx, b_idx, ptr_b;
  logic [AW-1:0]    a_addr, b_addr;
  logic [DW-1:0]    a_wd, b_wd;
  logic             conflict, b_gnt, a_en, b_en;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  tag_t             tag_q, tag_d;
  logic [CW-1:0]    coll_cnt_q, coll_cnt_d;

  dpram_rr_pick #(.NREQ(NREQ)) u_pick_a (
    .req(bus.req), .mask({NREQ{1'b1}}), .ptr(rr_ptr_q),
    .gnt_oh(a_oh), .valid(a_vld), .idx(a_idx)
  );

  always_comb begin
    a_we = 1'b0; a_addr = '0; a_wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (a_oh[i]) begin
        a_we   = bus.req_we[i];
        a_addr = bus.req_addr[i*AW +: AW];
        a_wd   = bus.req_wdata[i*DW +: DW];
      end
    end
  end

  // Only one read may return per cycle, so a read winner on A leaves B to writers only.
  assign ptr_b  = wrap_inc(a_idx, NREQ);
  assign mask_b = ~a_oh & (a_we ? {NREQ{1'b1}} : bus.req_we);

  dpram_rr_pick #(.NREQ(NREQ)) u_pick_b (
    .req(bus.req), .mask(mask_b), .ptr(ptr_b),
    .gnt_oh(b_oh), .valid(b_vld), .idx(b_idx)
  );

  always_comb begin
    b_we = 1'b0; b_addr = '0; b_wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (b_oh[i]) begin
        b_we   = bus.req_we[i];
        b_addr = bus.req_addr[i*AW +: AW];
        b_wd   = bus.req_wdata[i*DW +: DW];
      end
    end
  end

  assign conflict = a_vld && b_vld && (a_addr == b_addr) && (a_we || b_we);
  assign b_gnt    = b_vld && !conflict;
  assign a_en     = rst_n && a_vld;
  assign b_en     = rst_n && b_gnt;

  always_comb begin
    bus.gnt       = rst_n ? (a_oh | (b_gnt ? b_oh : '0)) : '0;
    bus.ram_ena   = a_en;
    bus.ram_wea   = a_en && a_we;
    bus.ram_addra = a_en ? a_addr : '0;
    bus.ram_dia   = a_en ? a_wd : '0;
    bus.ram_enb   = b_en;
    bus.ram_web   = b_en && b_we;
    bus.ram_addrb = b_en ? b_addr : '0;
    bus.ram_dib   = b_en ? b_wd : '0;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (b_gnt)      rr_ptr_d = wrap_inc(b_idx, NREQ);
    else if (a_vld) rr_ptr_d = wrap_inc(a_idx, NREQ);

    tag_d = '0;
    if (a_vld && !a_we)      tag_d = '{valid: 1'b1, idx: a_idx, port: PORT_A};
    else if (b_gnt && !b_we) tag_d = '{valid: 1'b1, idx: b_idx, port: PORT_B};

    coll_cnt_d = coll_cnt_q;
    if (conflict && (coll_cnt_q != '1)) coll_cnt_d = coll_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      tag_q      <= '0;
      coll_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag_q      <= tag_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  always_comb begin
    bus.rvalid = '0;
    for (int i = 0; i < NREQ; i++) bus.rvalid[i] = tag_q.valid && (tag_q.idx == IDX_W'(i));
    bus.rdata = '0;
    if (tag_q.valid) bus.rdata = (tag_q.port == PORT_B) ? bus.ram_dob : bus.ram_doa;
  end

  assign coll_cnt = coll_cnt_q;
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: behavioural RAM, request model and read-return scoreboard.
module tb_dpram_port_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int EW   = 4 + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpram_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
  dpram_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus2 ();
  logic [CW-1:0] coll_cnt;
  logic [3:0]    coll_cnt2;

  dpram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .coll_cnt(coll_cnt)
  );

  dpram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .coll_cnt(coll_cnt2)
  );

  // Dual-port RAM 64x16, registered read, old data on same-port read-during-write.
  logic [DW-1:0] ram [64] = '{default: '0};
  always @(posedge clk) begin
    if (bus.ram_ena) begin
      if (bus.ram_wea) ram[bus.ram_addra] <= bus.ram_dia;
      bus.ram_doa <= ram[bus.ram_addra];
    end
    if (bus.ram_enb) begin
      if (bus.ram_web) ram[bus.ram_addrb] <= bus.ram_dib;
      bus.ram_dob <= ram[bus.ram_addrb];
    end
  end
  assign bus2.ram_doa = '0;
  assign bus2.ram_dob = '0;

  // Requester state and reference model
  bit            p_pend [NREQ];
  bit            p_we   [NREQ];
  logic [AW-1:0] p_addr [NREQ];
  logic [DW-1:0] p_data [NREQ];
  int            p_wait [NREQ];
  logic [DW-1:0] m_mem  [64] = '{default: '0};
  int            m_ptr, m_coll;
  logic [EW-1:0] exp_q[$];
  int            checks, errors;
  logic [NREQ-1:0] last_gnt, mon_rv;
  logic [DW-1:0]   mon_rd;
  bit            repost, check_wait;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic post(input int i, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    p_pend[i] = 1'b1; p_we[i] = we; p_addr[i] = addr; p_data[i] = data; p_wait[i] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]                   = p_pend[i];
      bus.req_we[i]                = p_we[i];
      bus.req_addr[i*AW +: AW]     = p_addr[i];
      bus.req_wdata[i*DW +: DW]    = p_data[i];
    end
  endtask

  task automatic check_port(input string name, input int w, input logic en, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] di);
    if (w >= 0)
      chk(name, {en, we, addr, (p_we[w] ? di : 16'h0)},
                {1'b1, p_we[w], p_addr[w], (p_we[w] ? p_data[w] : 16'h0)});
    else
      chk(name, {en, we}, 2'b00);
  endtask

  // Evaluate this cycle's expected grants from the arbitration rules, then retire grants.
  task automatic check_cycle();
    int a, b, idx, g;
    bit coll;
    logic [NREQ-1:0] eg;
    a = -1; b = -1; coll = 1'b0;
    for (int i = 0; i < NREQ; i++) if (p_pend[i]) p_wait[i]++;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (a < 0 && p_pend[idx]) a = idx;
    end
    if (a >= 0)
      for (int k = 1; k < NREQ; k++) begin
        idx = (a + k) % NREQ;
        if (b < 0 && p_pend[idx] && (p_we[a] || p_we[idx])) b = idx;
      end
    if (b >= 0 && p_addr[a] == p_addr[b] && (p_we[a] || p_we[b])) begin
      coll = 1'b1;
      b = -1;
    end
    eg = '0;
    if (a >= 0) eg[a] = 1'b1;
    if (b >= 0) eg[b] = 1'b1;
    chk("gnt", bus.gnt, eg);
    check_port("port_a", a, bus.ram_ena, bus.ram_wea, bus.ram_addra, bus.ram_dia);
    check_port("port_b", b, bus.ram_enb, bus.ram_web, bus.ram_addrb, bus.ram_dib);
    chk("coll_cnt", coll_cnt, m_coll);
    if (coll) m_coll++;
    last_gnt = bus.gnt;
    for (int s = 0; s < 2; s++) begin
      g = (s == 0) ? a : b;
      if (g >= 0) begin
        if (p_we[g]) m_mem[p_addr[g]] = p_data[g];
        else exp_q.push_back({4'(g), m_mem[p_addr[g]]});
        if (check_wait) chk("wait_bound", (p_wait[g] <= NREQ), 1);
        p_pend[g] = 1'b0;
        if (repost) post(g, 1'b1, 6'(32 + g), 16'($urandom));
      end
    end
    if (b >= 0)      m_ptr = (b + 1) % NREQ;
    else if (a >= 0) m_ptr = (a + 1) % NREQ;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per read-return strobe.
  initial begin
    logic [EW-1:0]   e;
    logic [NREQ-1:0] ev;
    forever begin
      @(negedge clk);
      mon_rv = bus.rvalid;
      mon_rd = bus.rdata;
      if (rst_n && bus.rvalid !== '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rvalid_unexpected: got %b expected 0000 (t=%0t)", bus.rvalid, $time);
        end else begin
          e  = exp_q.pop_front();
          ev = '0;
          ev[e[EW-1 -: 4]] = 1'b1;
          chk("rvalid", bus.rvalid, ev);
          chk("rdata", bus.rdata, e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: got no end expected end by 500000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int busy;
    checks = 0; errors = 0; m_ptr = 0; m_coll = 0; repost = 0; check_wait = 0;
    for (int i = 0; i < NREQ; i++) begin
      p_pend[i] = 0; p_we[i] = 0; p_addr[i] = '0; p_data[i] = '0; p_wait[i] = 0;
    end
    bus.req = '1; bus.req_we = '1; bus.req_addr = '0; bus.req_wdata = '0;
    bus2.req = '0; bus2.req_we = '0; bus2.req_addr = '0; bus2.req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_ram_en", {bus.ram_ena, bus.ram_enb}, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_coll", coll_cnt, 0);
    bus.req = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Two writes together, then a read back
    post(0, 1, 6'd5, 16'h1234); post(1, 1, 6'd9, 16'hBEEF);
    step(); chk("t1_gnt", last_gnt, 4'b0011);
    post(2, 0, 6'd5, 16'h0);
    step(); chk("t1_rd_gnt", last_gnt, 4'b0100);
    step(); chk("t1_rvalid", mon_rv, 4'b0100); chk("t1_rdata", mon_rd, 16'h1234);

    // Write/read conflict on the same address
    post(0, 1, 6'd7, 16'hA5A5); post(1, 0, 6'd7, 16'h0);
    step(); chk("t2_gnt", last_gnt, 4'b0001); chk("t2_coll", coll_cnt, 1);
    step(); chk("t2_gnt2", last_gnt, 4'b0010);
    step(); chk("t2_rvalid", mon_rv, 4'b0010); chk("t2_rdata", mon_rd, 16'hA5A5);

    // All four hold writes to distinct addresses
    for (int i = 0; i < NREQ; i++) post(i, 1, 6'(32 + i), 16'($urandom));
    repost = 1; check_wait = 1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("t3_pair", last_gnt, (c % 2 == 0) ? 4'b1100 : 4'b0011);
    end
    repost = 0;
    step(); step();
    check_wait = 0;

    // Two reads are serialised
    post(1, 0, 6'd3, 16'h0); post(3, 0, 6'd4, 16'h0);
    step(); chk("t4_gnt1", last_gnt, 4'b1000);
    step(); chk("t4_gnt2", last_gnt, 4'b0010); chk("t4_rv1", mon_rv, 4'b1000);
    step(); chk("t4_rv2", mon_rv, 4'b0010);

    // Reset right after a read grant
    post(0, 0, 6'd5, 16'h0);
    step();
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) p_pend[i] = 0;
    m_ptr = 0; m_coll = 0;
    drive();
    @(negedge clk);
    chk("t5_rvalid_rst", bus.rvalid, 0);
    chk("t5_coll_rst", coll_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rvalid_rel", bus.rvalid, 0);
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) post(i, 1, 6'(40 + i), 16'($urandom));
    step(); chk("t5_gnt_restart", last_gnt, 4'b0011);
    step(); chk("t5_gnt_next", last_gnt, 4'b1100);

    // Random traffic on a narrow address range to provoke conflicts
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!p_pend[i] && $urandom_range(0, 1) == 1)
          post(i, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 16'($urandom));
      step();
    end
    busy = 1;
    for (int c = 0; c < 40 && busy != 0; c++) begin
      step();
      busy = 0;
      for (int i = 0; i < NREQ; i++) if (p_pend[i]) busy++;
    end
    chk("drain_pending", busy, 0);
    step(); step();
    chk("exp_q_empty", exp_q.size(), 0);

    // Saturating collision counter on the narrow-counter instance
    bus2.req = 4'b0011; bus2.req_we = 4'b0011;
    bus2.req_addr = {6'd0, 6'd0, 6'd1, 6'd1};
    repeat (10) @(posedge clk);
    #1 chk("t6_coll10", coll_cnt2, 10);
    repeat (10) @(posedge clk);
    #1 chk("t6_coll_sat", coll_cnt2, 15);
    bus2.req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
